stack_bus_lane_arbiter: RTL and testbench
=========================================

# stack_bus_lane_arbiter

- Parametrised successor to the fixed point-to-point downstream stack bus path.
- Merges `NUM_SRC` manager packet streams onto one shared stack-bus lane toward a PE.
- Arbitrates per packet, in round-robin or fixed-priority mode.
- Flow control toward the PE side is credit-based; the block reports credit and protocol status.
- Sits inside `stack_bus`, between the manager-array downstream ports and each PE-array downstream port.

## Interface
Parameters:
- `NUM_SRC`, 4: number of manager sources (≥2).
- `DATA_WIDTH`, 64: payload width per beat.
- `CREDITS`, 8: downstream buffer depth in beats (1..255).
- `ARB_MODE`, 0: 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- `clk`  in  1  single block clock.
- `reset_poweron`  in  1  asynchronous, active-low reset.
- `src__sbl__valid`  in  `NUM_SRC`  per-source beat valid.
- `src__sbl__cntl`  in  `2*NUM_SRC`  per-source framing: 2'b10 SOM, 2'b00 MOM, 2'b01 EOM, 2'b11 SOD (single-beat packet).
- `src__sbl__data`  in  `DATA_WIDTH*NUM_SRC`  per-source payload.
- `sbl__src__ready`  out  `NUM_SRC`  per-source beat accept.
- `sbl__dst__valid`  out  1  lane beat valid.
- `sbl__dst__cntl`  out  2  lane framing.
- `sbl__dst__data`  out  `DATA_WIDTH`  lane payload.
- `sbl__dst__src_id`  out  `$clog2(NUM_SRC)`  originating source.
- `dst__sbl__credit`  in  1  one-cycle pulse returns one credit.
- `sbl__stat__credits`  out  `$clog2(CREDITS+1)`  credits currently available.
- `sbl__stat__protocol_err`  out  1  sticky protocol error flag.

## Operation
- Source beat handshake: a beat transfers when `valid & ready` are both high in the same cycle.
- States:
  - IDLE: no packet owns the lane.
  - XFER: granted source owns the lane until its EOM or SOD beat.
- IDLE:
  - Candidates are sources with valid high and cntl SOM or SOD.
  - If any candidate exists and credits ≠ 0, the winner is chosen combinationally, its ready is asserted, and its first beat is accepted in the same cycle.
  - SOM → XFER. SOD → stay in IDLE.
- XFER:
  - Only the granted source's ready can be high; ready = (credits ≠ 0).
  - An accepted EOM, or an accepted SOD (protocol error, see below), returns the block to IDLE.
- Round-robin pointer:
  - After the final beat of a packet, the pointer becomes (grant+1) mod `NUM_SRC`.
  - Search starts at the pointer. Reset value is 0.
  - In `ARB_MODE` 1 the pointer is ignored.
- Credits:
  - Each accepted beat consumes 1 credit; each `dst__sbl__credit` pulse returns 1.
  - Consume and return in the same cycle leave the count unchanged.
  - A return while the count equals `CREDITS` saturates the count and sets the error flag.
- Protocol errors (set the sticky flag; cleared only by reset):
  - In IDLE, a valid beat with MOM or EOM: that source's ready is asserted, the beat is discarded, not forwarded, and consumes no credit.
  - In XFER, the granted source presents SOM: the beat is forwarded unchanged and the packet continues.
  - In XFER, the granted source presents SOD: the beat is forwarded and the packet ends.
- Ungranted sources during XFER: ready stays 0 and their beats are held; this is not an error.

## Timing
- Output register: each accepted beat appears on `sbl__dst__*` exactly 1 cycle after acceptance, with valid high for one cycle per beat.
- The lane has no backpressure.
- Throughput is 1 beat/cycle while credits ≠ 0.
- Ready is computed from the registered credit count, so a returned credit is usable the cycle after the pulse.
- Arbitration costs no extra cycles: back-to-back packets from different sources run gap-free when credits allow.
- Reset values:
  - `sbl__dst__valid` 0, `sbl__dst__cntl` 0, `sbl__dst__data` 0, `sbl__dst__src_id` 0.
  - `sbl__src__ready` all 0 during reset.
  - `sbl__stat__credits` = `CREDITS`, `sbl__stat__protocol_err` 0.
  - State IDLE, round-robin pointer 0.
- Reset mid-packet: the partial packet is abandoned, the in-flight output beat is dropped, and the credit count is restored to `CREDITS`. The downstream is reset by the same `reset_poweron`.

## Structure
- Shared package `stack_bus_pkg` holds:
  - cntl encodings SOM/MOM/EOM/SOD;
  - the `ARB_MODE` enum;
  - the state enum IDLE/XFER.
- One sub-module, `stack_bus_rr_arbiter`:
  - parametrised rotate-priority encoder;
  - inputs: request vector and pointer;
  - outputs: one-hot grant and encoded index;
  - shared by both modes, with the pointer tied to 0 for fixed priority.
- The credit counter, FSM and output register live in the top-level module.

## Test plan
- **Round-robin fairness.** `NUM_SRC`=4, all sources stream 3-beat packets continuously → grant order 0,1,2,3,0; `src_id` constant within each packet; no idle cycles between packets.
- **Fixed priority.** `ARB_MODE`=1, sources 1 and 3 both request SOM → source 1 wins every time while it keeps requesting; source 3 waits.
- **Credit exhaustion.** `CREDITS`=2, no returns, source 0 sends a 4-beat packet → exactly 2 beats forwarded, ready low, `sbl__stat__credits`=0. One credit pulse → 1 more beat, forwarded 2 cycles after the pulse.
- **Simultaneous consume and return.** Credit pulse every cycle during a 5-beat packet with credits=1 → count stays 1 and all 5 beats flow at 1/cycle.
- **Protocol errors.** MOM in IDLE → beat discarded, no output beat, flag=1. Credit pulse at full count → count stays `CREDITS`, flag=1.
- **Mid-packet reset.** Assert `reset_poweron`=0 after beat 2 of 4 → outputs 0 immediately, credits = `CREDITS`. After release, a new SOD from source 2 is forwarded with `src_id`=2.

Source files
------------

// File: rtl/stack_bus_pkg.sv
// -----------------------------------------------------------------------------
// stack_bus_pkg
// Shared definitions for the stack bus lane logic.
//   - cntl framing encodings (SOM / MOM / EOM / SOD)
//   - arbitration mode enum
//   - lane ownership state enum
//   - small helpers to classify a framing code
// -----------------------------------------------------------------------------
package stack_bus_pkg;

    // Framing codes. Bit 1 marks a packet head (SOM/SOD), bit 0 marks a
    // packet tail (EOM/SOD); SOD is both head and tail.
    localparam logic [1:0] CNTL_MOM = 2'b00;
    localparam logic [1:0] CNTL_EOM = 2'b01;
    localparam logic [1:0] CNTL_SOM = 2'b10;
    localparam logic [1:0] CNTL_SOD = 2'b11;

    typedef enum logic {
        ARB_ROUND_ROBIN = 1'b0,
        ARB_FIXED_PRIO  = 1'b1
    } arb_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_e;

    // True for SOM or SOD: the beat opens a packet.
    function automatic logic cntl_is_head(input logic [1:0] cntl);
        return cntl[1];
    endfunction

    // True for EOM or SOD: the beat closes a packet.
    function automatic logic cntl_is_tail(input logic [1:0] cntl);
        return cntl[0];
    endfunction

endpackage

// File: rtl/stack_bus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// stack_bus_rr_arbiter
// Rotate-priority encoder: the first requester found when scanning upward
// from 'ptr' (wrapping at NUM_REQ) wins. Tie 'ptr' to 0 for plain fixed
// priority (lowest index wins).
// Ports:
//   req         in   NUM_REQ    request vector
//   ptr         in   IW         index where the scan starts
//   grant       out  NUM_REQ    one-hot grant (all zero when no request)
//   grant_idx   out  IW         encoded winner index
//   grant_valid out  1          at least one request present
// -----------------------------------------------------------------------------
module stack_bus_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       grant_valid
);

    localparam int IW = $clog2(NUM_REQ);

    // Scan all positions starting at ptr; the first hit sticks.
    always_comb begin
        int              cand_s;
        logic [IW-1:0]   cand_idx_s;
        logic            hit_s;
        logic [NUM_REQ-1:0] onehot_s;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand_s      = 0;
        cand_idx_s  = '0;
        hit_s       = 1'b0;
        onehot_s    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_s = int'(ptr) + i;
            cand_s = (cand_s >= NUM_REQ) ? (cand_s - NUM_REQ) : cand_s;
            cand_idx_s = IW'(cand_s);
            hit_s      = !grant_valid && req[cand_idx_s];
            onehot_s   = '0;
            onehot_s[cand_idx_s] = 1'b1;
            grant       = hit_s ? onehot_s : grant;
            grant_idx   = hit_s ? cand_idx_s : grant_idx;
            grant_valid = grant_valid | hit_s;
        end
    end

endmodule

// File: rtl/stack_bus_lane_arbiter.sv
// -----------------------------------------------------------------------------
// stack_bus_lane_arbiter
// Merges NUM_SRC manager packet streams onto one credit-flow-controlled
// stack-bus lane toward a PE. Arbitration is per packet (round-robin or
// fixed priority); a packet owns the lane from its head beat to its tail.
// Ports:
//   clk                      in   1                   block clock
//   reset_poweron            in   1                   async active-low reset
//   src__sbl__valid          in   NUM_SRC             per-source beat valid
//   src__sbl__cntl           in   2*NUM_SRC           per-source framing
//   src__sbl__data           in   DATA_WIDTH*NUM_SRC  per-source payload
//   sbl__src__ready          out  NUM_SRC             per-source beat accept
//   sbl__dst__valid          out  1                   lane beat valid
//   sbl__dst__cntl           out  2                   lane framing
//   sbl__dst__data           out  DATA_WIDTH          lane payload
//   sbl__dst__src_id         out  clog2(NUM_SRC)      originating source
//   dst__sbl__credit         in   1                   credit return pulse
//   sbl__stat__credits       out  clog2(CREDITS+1)    credits available
//   sbl__stat__protocol_err  out  1                   sticky protocol error
// -----------------------------------------------------------------------------
module stack_bus_lane_arbiter
    import stack_bus_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int CREDITS    = 8,
    parameter int ARB_MODE   = 0
) (
    input  logic                            clk,
    input  logic                            reset_poweron,
    input  logic [NUM_SRC-1:0]              src__sbl__valid,
    input  logic [2*NUM_SRC-1:0]            src__sbl__cntl,
    input  logic [DATA_WIDTH*NUM_SRC-1:0]   src__sbl__data,
    output logic [NUM_SRC-1:0]              sbl__src__ready,
    output logic                            sbl__dst__valid,
    output logic [1:0]                      sbl__dst__cntl,
    output logic [DATA_WIDTH-1:0]           sbl__dst__data,
    output logic [$clog2(NUM_SRC)-1:0]      sbl__dst__src_id,
    input  logic                            dst__sbl__credit,
    output logic [$clog2(CREDITS+1)-1:0]    sbl__stat__credits,
    output logic                            sbl__stat__protocol_err
);

    localparam int IW = $clog2(NUM_SRC);
    localparam int CW = $clog2(CREDITS+1);
    localparam logic [CW-1:0] CREDITS_MAX = CW'(CREDITS);
    localparam logic [IW-1:0] LAST_IDX    = IW'(NUM_SRC-1);
    localparam arb_mode_e     MODE        = arb_mode_e'(ARB_MODE[0]);

    // Registered state
    state_e                 state_r;
    logic [IW-1:0]          owner_r;
    logic [IW-1:0]          ptr_r;
    logic [CW-1:0]          credits_r;
    logic                   err_r;
    logic                   dst_valid_r;
    logic [1:0]             dst_cntl_r;
    logic [DATA_WIDTH-1:0]  dst_data_r;
    logic [IW-1:0]          dst_src_id_r;

    // Combinational decode
    logic [1:0]             cntl_s [NUM_SRC];
    logic [DATA_WIDTH-1:0]  data_s [NUM_SRC];
    logic [NUM_SRC-1:0]     head_req_s;
    logic [NUM_SRC-1:0]     stray_s;
    logic [NUM_SRC-1:0]     arb_grant_s;
    logic [IW-1:0]          arb_idx_s;
    logic                   arb_valid_s;
    logic [IW-1:0]          arb_ptr_s;
    logic                   credit_avail_s;
    logic [NUM_SRC-1:0]     ready_s;
    logic                   accept_s;
    logic                   pkt_end_s;
    logic                   err_evt_s;
    logic [IW-1:0]          sel_idx_s;
    logic [IW-1:0]          ptr_next_s;
    state_e                 next_state_s;
    logic [CW-1:0]          credits_next_s;
    logic                   credit_over_s;

    // Slice the flattened source buses and classify each presented beat.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            cntl_s[i]     = src__sbl__cntl[2*i +: 2];
            data_s[i]     = src__sbl__data[DATA_WIDTH*i +: DATA_WIDTH];
            head_req_s[i] = src__sbl__valid[i] &&  cntl_is_head(cntl_s[i]);
            stray_s[i]    = src__sbl__valid[i] && !cntl_is_head(cntl_s[i]);
        end
    end

    assign arb_ptr_s      = (MODE == ARB_FIXED_PRIO) ? '0 : ptr_r;
    assign credit_avail_s = (credits_r != '0);
    assign ptr_next_s     = (sel_idx_s == LAST_IDX) ? '0 : (sel_idx_s + IW'(1));

    stack_bus_rr_arbiter #(
        .NUM_REQ     (NUM_SRC)
    ) u_arb (
        .req         (head_req_s),
        .ptr         (arb_ptr_s),
        .grant       (arb_grant_s),
        .grant_idx   (arb_idx_s),
        .grant_valid (arb_valid_s)
    );

    // Ready generation, beat acceptance and next-state decision.
    always_comb begin
        ready_s      = '0;
        accept_s     = 1'b0;
        pkt_end_s    = 1'b0;
        err_evt_s    = 1'b0;
        sel_idx_s    = owner_r;
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                // Headless beats (MOM/EOM) are swallowed here without a credit.
                ready_s   = stray_s;
                err_evt_s = |stray_s;
                sel_idx_s = arb_idx_s;
                if (arb_valid_s && credit_avail_s) begin
                    ready_s      = stray_s | arb_grant_s;
                    accept_s     = 1'b1;
                    pkt_end_s    = cntl_is_tail(cntl_s[arb_idx_s]);
                    next_state_s = pkt_end_s ? ST_IDLE : ST_XFER;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_XFER: begin
                ready_s[owner_r] = credit_avail_s;
                accept_s         = src__sbl__valid[owner_r] && credit_avail_s;
                if (accept_s) begin
                    // A head code inside a packet is forwarded but flagged;
                    // SOD additionally closes the packet.
                    pkt_end_s    = cntl_is_tail(cntl_s[owner_r]);
                    err_evt_s    = cntl_is_head(cntl_s[owner_r]);
                    next_state_s = pkt_end_s ? ST_IDLE : ST_XFER;
                end else begin
                    next_state_s = ST_XFER;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Credit count next value: consume and return together cancel out.
    always_comb begin
        credits_next_s = credits_r;
        credit_over_s  = 1'b0;
        case ({accept_s, dst__sbl__credit})
            2'b10: begin
                credits_next_s = credits_r - CW'(1);
            end
            2'b01: begin
                if (credits_r == CREDITS_MAX) begin
                    credit_over_s  = 1'b1;
                    credits_next_s = credits_r;
                end else begin
                    credits_next_s = credits_r + CW'(1);
                end
            end
            default: begin
                credits_next_s = credits_r;
            end
        endcase
    end

    // Lane ownership FSM and round-robin pointer.
    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            state_r <= ST_IDLE;
            owner_r <= '0;
            ptr_r   <= '0;
        end else begin
            state_r <= next_state_s;
            if (accept_s && (state_r == ST_IDLE)) begin
                owner_r <= sel_idx_s;
            end
            if (accept_s && pkt_end_s) begin
                ptr_r <= ptr_next_s;
            end
        end
    end

    // Credit counter and sticky protocol error flag.
    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            credits_r <= CREDITS_MAX;
            err_r     <= 1'b0;
        end else begin
            credits_r <= credits_next_s;
            err_r     <= err_r | err_evt_s | credit_over_s;
        end
    end

    // Lane output register: one cycle of latency, valid for one cycle per beat.
    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            dst_valid_r  <= 1'b0;
            dst_cntl_r   <= 2'b00;
            dst_data_r   <= '0;
            dst_src_id_r <= '0;
        end else begin
            dst_valid_r <= accept_s;
            if (accept_s) begin
                dst_cntl_r   <= cntl_s[sel_idx_s];
                dst_data_r   <= data_s[sel_idx_s];
                dst_src_id_r <= sel_idx_s;
            end
        end
    end

    // Ready is combinational so the first beat is taken in the grant cycle;
    // it is forced low while reset is held.
    assign sbl__src__ready         = reset_poweron ? ready_s : '0;
    assign sbl__dst__valid         = dst_valid_r;
    assign sbl__dst__cntl          = dst_cntl_r;
    assign sbl__dst__data          = dst_data_r;
    assign sbl__dst__src_id        = dst_src_id_r;
    assign sbl__stat__credits      = credits_r;
    assign sbl__stat__protocol_err = err_r;

endmodule

// File: tb/tb_stack_bus_lane_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for stack_bus_lane_arbiter. Two instances run side by side:
// inst 0 round-robin, inst 1 fixed priority, both with CREDITS=3.
// A reference model (lane owner, pointer, credit count as plain integers)
// predicts ready and pushes each forwarded beat into a queue; a monitor
// pops and compares whenever the lane presents a beat.
// -----------------------------------------------------------------------------
module tb_stack_bus_lane_arbiter;
    import stack_bus_pkg::*;

    localparam int NS = 4;
    localparam int DW = 32;
    localparam int CR = 3;
    localparam int IW = 2;
    localparam int CW = 2;

    typedef struct packed {
        logic [1:0]    c;
        logic [DW-1:0] d;
        logic [IW-1:0] id;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NS-1:0]    valid  [2];
    logic [2*NS-1:0]  cntl   [2];
    logic [DW*NS-1:0] data   [2];
    logic             credit [2];
    logic [NS-1:0]    ready  [2];
    logic             dvalid [2];
    logic [1:0]       dcntl  [2];
    logic [DW-1:0]    ddata  [2];
    logic [IW-1:0]    did    [2];
    logic [CW-1:0]    dcred  [2];
    logic             derr   [2];

    stack_bus_lane_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .CREDITS(CR), .ARB_MODE(0)) u_rr (
        .clk(clk), .reset_poweron(rst_n),
        .src__sbl__valid(valid[0]), .src__sbl__cntl(cntl[0]), .src__sbl__data(data[0]),
        .sbl__src__ready(ready[0]), .sbl__dst__valid(dvalid[0]), .sbl__dst__cntl(dcntl[0]),
        .sbl__dst__data(ddata[0]), .sbl__dst__src_id(did[0]), .dst__sbl__credit(credit[0]),
        .sbl__stat__credits(dcred[0]), .sbl__stat__protocol_err(derr[0]));

    stack_bus_lane_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .CREDITS(CR), .ARB_MODE(1)) u_fp (
        .clk(clk), .reset_poweron(rst_n),
        .src__sbl__valid(valid[1]), .src__sbl__cntl(cntl[1]), .src__sbl__data(data[1]),
        .sbl__src__ready(ready[1]), .sbl__dst__valid(dvalid[1]), .sbl__dst__cntl(dcntl[1]),
        .sbl__dst__data(ddata[1]), .sbl__dst__src_id(did[1]), .dst__sbl__credit(credit[1]),
        .sbl__stat__credits(dcred[1]), .sbl__stat__protocol_err(derr[1]));

    int tests = 0;
    int fails = 0;

    // Source state
    bit            pres   [2][NS];
    logic [1:0]    pc     [2][NS];
    logic [DW-1:0] pd     [2][NS];
    bit            pstray [2][NS];
    int            plen   [2][NS];
    int            ppos   [2][NS];

    // Reference model
    int m_owner [2];
    int m_ptr   [2];
    int m_cred  [2];
    bit m_err   [2];
    int outst   [2];
    beat_t q0[$];
    beat_t q1[$];

    // Knobs
    int p_new = 0;
    int p_ret = 0;
    bit inject = 1'b0;
    bit force_ret = 1'b0;

    task automatic reset_model();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1; m_ptr[k] = 0; m_cred[k] = CR; m_err[k] = 1'b0; outst[k] = 0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic clear_sources();
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < NS; s++) begin
                pres[k][s] = 1'b0; pc[k][s] = 2'b00; pd[k][s] = '0;
                pstray[k][s] = 1'b0; plen[k][s] = 0; ppos[k][s] = 0;
            end
            valid[k] = '0; cntl[k] = '0; data[k] = '0; credit[k] = 1'b0;
        end
    endtask

    task automatic gen_beat(int k, int s);
        pd[k][s] = $urandom;
        if (inject && $urandom_range(0, 7) == 0) begin
            pstray[k][s] = 1'b1;
            if (ppos[k][s] == 0) pc[k][s] = ($urandom_range(0, 1) == 1) ? CNTL_MOM : CNTL_EOM;
            else                 pc[k][s] = ($urandom_range(0, 1) == 1) ? CNTL_SOM : CNTL_SOD;
        end else begin
            pstray[k][s] = 1'b0;
            if (ppos[k][s] == 0) begin
                plen[k][s] = $urandom_range(1, 4);
                pc[k][s] = (plen[k][s] == 1) ? CNTL_SOD : CNTL_SOM;
            end else if (ppos[k][s] == plen[k][s] - 1) begin
                pc[k][s] = CNTL_EOM;
            end else begin
                pc[k][s] = CNTL_MOM;
            end
        end
        pres[k][s] = 1'b1;
    endtask

    task automatic src_accept(int k, int s);
        pres[k][s] = 1'b0;
        if (pc[k][s][0]) ppos[k][s] = 0;
        else if (!pstray[k][s]) ppos[k][s] = ppos[k][s] + 1;
    endtask

    task automatic push_beat(int k, beat_t b);
        if (k == 0) q0.push_back(b);
        else        q1.push_back(b);
    endtask

    // One cycle of the reference model: predict ready, then commit the edge.
    task automatic model_cycle(int k);
        logic [NS-1:0] exp;
        int fwd;
        int start;
        int s;
        bit found;
        bit consume;
        beat_t b;
        exp = '0; fwd = -1; found = 1'b0; consume = 1'b0;
        if (m_owner[k] < 0) begin
            for (int i = 0; i < NS; i++) if (pres[k][i] && !pc[k][i][1]) exp[i] = 1'b1;
            if (m_cred[k] > 0) begin
                start = (k == 1) ? 0 : m_ptr[k];
                for (int j = 0; j < NS; j++) begin
                    s = (start + j) % NS;
                    if (!found && pres[k][s] && pc[k][s][1]) begin fwd = s; found = 1'b1; end
                end
            end
        end else begin
            if (m_cred[k] > 0) begin
                exp[m_owner[k]] = 1'b1;
                if (pres[k][m_owner[k]]) fwd = m_owner[k];
            end
        end
        if (fwd >= 0) exp[fwd] = 1'b1;
        tests++;
        if (ready[k] !== exp) begin
            fails++;
            $display("FAIL ready inst%0d t=%0t: got %b want %b", k, $time, ready[k], exp);
        end
        if (m_owner[k] < 0) begin
            for (int i = 0; i < NS; i++) begin
                if (exp[i] && i != fwd) begin m_err[k] = 1'b1; src_accept(k, i); end
            end
        end
        if (fwd >= 0) begin
            b.c = pc[k][fwd]; b.d = pd[k][fwd]; b.id = IW'(fwd);
            push_beat(k, b);
            consume = 1'b1;
            if (m_owner[k] >= 0 && pc[k][fwd][1]) m_err[k] = 1'b1;
            if (pc[k][fwd][0]) begin m_owner[k] = -1; m_ptr[k] = (fwd + 1) % NS; end
            else m_owner[k] = fwd;
            src_accept(k, fwd);
        end
        if (consume && !credit[k]) m_cred[k] = m_cred[k] - 1;
        else if (credit[k] && !consume) begin
            if (m_cred[k] == CR) m_err[k] = 1'b1;
            else m_cred[k] = m_cred[k] + 1;
        end
        if (consume) outst[k] = outst[k] + 1;
        if (credit[k] && outst[k] > 0) outst[k] = outst[k] - 1;
    endtask

    // Drive one cycle of stimulus at the falling edge, then run the model.
    task automatic step();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < NS; s++) begin
                if (!pres[k][s] && $urandom_range(0, 99) < p_new) gen_beat(k, s);
                valid[k][s] = pres[k][s];
                cntl[k][2*s +: 2] = pc[k][s];
                data[k][DW*s +: DW] = pd[k][s];
            end
            credit[k] = force_ret || (outst[k] > 0 && $urandom_range(0, 99) < p_ret);
        end
        #1;
        for (int k = 0; k < 2; k++) model_cycle(k);
    endtask

    // Monitor: pops the scoreboard whenever the lane presents a beat.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            beat_t e;
            bit have;
            have = 1'b0;
            e = '0;
            if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            else if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            tests++;
            if (dvalid[k] !== have) begin
                fails++;
                $display("FAIL dst_valid inst%0d t=%0t: got %b want %b", k, $time, dvalid[k], have);
            end else if (have) begin
                tests++;
                if ({dcntl[k], ddata[k], did[k]} !== e) begin
                    fails++;
                    $display("FAIL dst_beat inst%0d t=%0t: got c=%b d=%h id=%0d want c=%b d=%h id=%0d",
                             k, $time, dcntl[k], ddata[k], did[k], e.c, e.d, e.id);
                end
            end
            tests++;
            if (dcred[k] !== CW'(m_cred[k])) begin
                fails++;
                $display("FAIL credits inst%0d t=%0t: got %0d want %0d", k, $time, dcred[k], m_cred[k]);
            end
            tests++;
            if (derr[k] !== m_err[k]) begin
                fails++;
                $display("FAIL protocol_err inst%0d t=%0t: got %b want %b", k, $time, derr[k], m_err[k]);
            end
        end
    end

    task automatic check_val(string name, int k, logic [63:0] got, logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s inst%0d: got %0h want %0h", name, k, got, want);
        end
    endtask

    task automatic check_reset_outputs();
        for (int k = 0; k < 2; k++) begin
            check_val("rst_ready", k, 64'(ready[k]), 64'd0);
            check_val("rst_dst_valid", k, 64'(dvalid[k]), 64'd0);
            check_val("rst_dst_cntl", k, 64'(dcntl[k]), 64'd0);
            check_val("rst_dst_data", k, 64'(ddata[k]), 64'd0);
            check_val("rst_dst_src_id", k, 64'(did[k]), 64'd0);
            check_val("rst_credits", k, 64'(dcred[k]), 64'(CR));
            check_val("rst_err", k, 64'(derr[k]), 64'd0);
        end
    endtask

    initial begin
        int guard;
        clear_sources();
        reset_model();
        // Sources presenting during reset must still see ready low.
        for (int s = 0; s < NS; s++) begin
            valid[0][s] = 1'b1; valid[1][s] = 1'b1;
        end
        repeat (3) @(negedge clk);
        check_reset_outputs();
        clear_sources();
        rst_n = 1'b1;

        // Legal random traffic.
        p_new = 70; p_ret = 60; inject = 1'b0;
        repeat (1500) step();

        // Credit exhaustion: no returns while sources keep pushing.
        p_new = 100; p_ret = 0;
        repeat (30) step();
        check_val("exhausted_credits", 0, 64'(dcred[0]), 64'd0);
        check_val("exhausted_credits", 1, 64'(dcred[1]), 64'd0);
        // Refill every cycle, sources idle, then one surplus return.
        p_new = 0; p_ret = 100;
        repeat (20) step();
        force_ret = 1'b1;
        step();
        force_ret = 1'b0;
        step();
        check_val("over_return_err", 0, 64'(derr[0]), 64'd1);
        check_val("over_return_credits", 0, 64'(dcred[0]), 64'(CR));

        // Random traffic with protocol violations mixed in.
        p_new = 70; p_ret = 60; inject = 1'b1;
        repeat (1200) step();
        inject = 1'b0;

        // Mid-packet reset: wait for inst 0 to own the lane.
        guard = 0;
        while (m_owner[0] < 0 && guard < 200) begin step(); guard++; end
        tests++;
        if (m_owner[0] < 0) begin
            fails++;
            $display("FAIL wait_owner inst0: got no owner want owner within 200 cycles");
        end
        #2;
        rst_n = 1'b0;
        reset_model();
        #1;
        check_reset_outputs();
        clear_sources();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single-beat packet from source 2 after reset.
        p_new = 0; p_ret = 100;
        for (int k = 0; k < 2; k++) begin
            pres[k][2] = 1'b1; pc[k][2] = CNTL_SOD; pd[k][2] = $urandom; pstray[k][2] = 1'b0;
        end
        step();
        step();
        check_val("post_reset_src_id", 0, 64'(did[0]), 64'd2);
        check_val("post_reset_src_id", 1, 64'(did[1]), 64'd2);

        p_new = 60; p_ret = 60;
        repeat (400) step();
        p_new = 0; p_ret = 100;
        repeat (20) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
